decode_stage: RTL
=================

Name: decode_stage

Overview: Registered, handshaked successor of the combinational decoder for the Jac1-8 core. It sits between fetch and the register file/ALU and has a 1-cycle decode latency with valid/ready on both sides. It stalls conditional branches until the in-flight ALU status is written, and it kills the wrong-path instruction after a taken branch.

Parameters:
INSTR_WIDTH, 16, instruction word width
OPCODE_BITS, 5, opcode field instruction[INSTR_WIDTH-1 -: OPCODE_BITS]
SEL_WIDTH, 2, register select width (2**SEL_WIDTH registers)
PARAM_BITS, 8, literal/offset field instruction[PARAM_BITS-1:0]
STATUS_BITS, 6, status vector width; bit2 zero, bit3 equal, bit4 greater, bit5 smaller
OP1_POS, 9, MSB of operand-1 field, width SEL_WIDTH
OP2_POS, 4, MSB of operand-2 field, width SEL_WIDTH

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low, on one clock clk
in_valid  in  1  fetch offers instruction
in_ready  out  1  stage accepts (transfer = in_valid & in_ready)
instruction  in  INSTR_WIDTH  instruction word
status  in  STATUS_BITS  current status register
status_valid  in  1  one-cycle pulse: status register updated by ALU
out_ready  in  1  downstream accepts bundle
out_valid  out  1  decoded bundle valid
opcode  out  OPCODE_BITS  registered opcode
rd_en1, rd_en2  out  1 each  register read enables
rd_sel1, rd_sel2  out  SEL_WIDTH each  read selects
wr_en  out  1  register write enable
wr_sel  out  SEL_WIDTH  write select
sel_reg_in_alu_decoder  out  1  1 = ALU result, 0 = param, to register input
param  out  PARAM_BITS  literal / jump target / offset
stat_wr_en  out  1  status write enable
cnt_wr_en  out  1  program counter load
add_offset  out  1  1 = PC relative, 0 = absolute
flush  out  1  taken branch, valid with out_valid
illegal  out  1  reserved opcode decoded

Behaviour:
- Reset: all outputs are 0, in_ready=0 while rst_n=0. The state is RUN and flags_pending=0. Reset in any state drops any captured instruction.
- in_ready = rst_n & state!=WAIT_FLAGS & (!out_valid | out_ready).
- Output hold: while out_valid & !out_ready, every output is frozen.
- Decode, registered 1 cycle after transfer:
  - ADD/SUB/AND/OR/XOR: rd_en1=rd_en2=1, rd_sel1=wr_sel=op1, rd_sel2=op2, wr_en=1, sel=1, stat_wr_en=1.
  - NOT: rd_en2=1, rd_sel2=op2, rd_en1=0, wr_sel=op1, wr_en=1, sel=1, stat_wr_en=1.
  - SHL/SHR: rd_en1=1, rd_sel1=wr_sel=op1, param=shift, wr_en=1, sel=1, stat_wr_en=1.
  - VAL: wr_en=1, wr_sel=op1, sel=0, param=literal.
  - GOTO: cnt_wr_en=1, add_offset=0, flush=1.
  - IFZ/IFNZ/IFEQ/IFST/IFGT: if the condition (status bit, or its negation for IFNZ) is true, then cnt_wr_en=add_offset=flush=1; otherwise all enables are 0.
  - Reserved opcodes and NOP: all enables are 0; illegal=1 for reserved opcodes only.
  - Unused selects read as 0.
- flags_pending: set on transfer of any stat_wr_en instruction, cleared on status_valid. Set wins when both occur in the same cycle. status_valid with flags_pending=0 is ignored.
- FSM states are RUN, WAIT_FLAGS and KILL.
  - RUN, conditional branch transferred with flags_pending=1 → WAIT_FLAGS. The branch is captured and out_valid stays 0.
  - WAIT_FLAGS → on status_valid, evaluate the captured branch using the status value of that cycle. out_valid rises next cycle; the state becomes KILL if the branch is taken, else RUN.
  - RUN, branch taken with no pending flags → KILL, together with out_valid.
  - KILL: the next transferred instruction is discarded (out_valid=0), then → RUN.
- Each in-order transfer yields exactly one bundle, except instructions discarded in KILL.

Decomposition:
- Package jac_pkg: opcode constants, status bit indices, and the SEL_ALU/SEL_DECODER constants.
- One combinational sub-module, decode_table (opcode/fields → control bundle); decode_stage wraps it with the registers and the FSM.

Test Plan:
- After reset, ADD with op1=01 and op2=10 → the next cycle has out_valid=1, rd_sel1=01, rd_sel2=10, wr_sel=01, stat_wr_en=1 and flush=0.
- out_ready=0 for 3 cycles after a VAL with op1=11 and param=A5 → param=A5 and wr_sel=11 are held and in_ready=0; one bundle is delivered when out_ready=1.
- SUB then IFZ with offset 09, and status_valid asserted 4 cycles later with status[2]=1 → in_ready=0 during the wait; one cycle after the pulse the bench sees cnt_wr_en=add_offset=flush=1 and param=09.
- GOTO 3F followed by an XOR → flush=1 and add_offset=0; the XOR is accepted but never reaches out_valid; the following NOP reaches out_valid.
- IFEQ with status[3]=0 → out_valid=1 with all enables 0 and no instruction killed. An opcode of 11010 → illegal=1 and wr_en=0.
- rst_n=0 during WAIT_FLAGS → the next cycle has out_valid=0 and flags_pending=0; a later status_valid produces no bundle.

Source files
------------

// File: rtl/jac_pkg.sv
// Shared constants for the Jac1-8 decode path: opcode map, status bit
// positions, register-input mux encoding and decode FSM states.
package jac_pkg;

    typedef enum logic [4:0] {
        OP_NOP  = 5'b00000,
        OP_ADD  = 5'b00001,
        OP_SUB  = 5'b00010,
        OP_AND  = 5'b00011,
        OP_OR   = 5'b00100,
        OP_XOR  = 5'b00101,
        OP_NOT  = 5'b00110,
        OP_SHL  = 5'b00111,
        OP_SHR  = 5'b01000,
        OP_VAL  = 5'b01001,
        OP_GOTO = 5'b01010,
        OP_IFZ  = 5'b01011,
        OP_IFNZ = 5'b01100,
        OP_IFEQ = 5'b01101,
        OP_IFST = 5'b01110,
        OP_IFGT = 5'b01111
    } opcode_e;

    // Status vector bit positions
    localparam int ST_ZERO    = 2;
    localparam int ST_EQUAL   = 3;
    localparam int ST_GREATER = 4;
    localparam int ST_SMALLER = 5;

    // Register-input mux: ALU result or decoder literal
    localparam logic SEL_ALU     = 1'b1;
    localparam logic SEL_DECODER = 1'b0;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        WAIT_FLAGS = 2'd1,
        KILL       = 2'd2
    } state_e;

endpackage

// File: rtl/decode_table.sv
// Combinational instruction decode: opcode and fields to control bundle.
// Branch conditions are resolved against the status value presented here.
module decode_table
    import jac_pkg::*;
#(
    parameter int INSTR_WIDTH = 16,
    parameter int OPCODE_BITS = 5,
    parameter int SEL_WIDTH   = 2,
    parameter int PARAM_BITS  = 8,
    parameter int STATUS_BITS = 6,
    parameter int OP1_POS     = 9,
    parameter int OP2_POS     = 4
) (
    input  logic [INSTR_WIDTH-1:0] instr_i,
    input  logic [STATUS_BITS-1:0] status_i,
    output logic [OPCODE_BITS-1:0] opcode_o,
    output logic                   rd_en1_o,
    output logic                   rd_en2_o,
    output logic [SEL_WIDTH-1:0]   rd_sel1_o,
    output logic [SEL_WIDTH-1:0]   rd_sel2_o,
    output logic                   wr_en_o,
    output logic [SEL_WIDTH-1:0]   wr_sel_o,
    output logic                   sel_o,
    output logic [PARAM_BITS-1:0]  param_o,
    output logic                   stat_wr_en_o,
    output logic                   cnt_wr_en_o,
    output logic                   add_offset_o,
    output logic                   flush_o,
    output logic                   illegal_o,
    output logic                   is_cond_o
);

    logic [OPCODE_BITS-1:0] opc;
    logic [SEL_WIDTH-1:0]   op1, op2;
    logic [PARAM_BITS-1:0]  prm;
    logic                   cond;
    logic                   unused_ok;

    assign opc       = instr_i[INSTR_WIDTH-1 -: OPCODE_BITS];
    assign op1       = instr_i[OP1_POS -: SEL_WIDTH];
    assign op2       = instr_i[OP2_POS -: SEL_WIDTH];
    assign prm       = instr_i[PARAM_BITS-1:0];
    assign opcode_o  = opc;
    assign unused_ok = ^{instr_i, status_i};

    // Branch condition for the conditional opcodes
    always_comb begin
        cond = 1'b0;
        case (opcode_e'(opc))
            OP_IFZ:  cond = status_i[ST_ZERO];
            OP_IFNZ: cond = !status_i[ST_ZERO];
            OP_IFEQ: cond = status_i[ST_EQUAL];
            OP_IFST: cond = status_i[ST_SMALLER];
            OP_IFGT: cond = status_i[ST_GREATER];
            default: cond = 1'b0;
        endcase
    end

    // Control bundle; anything not driven by an opcode stays 0
    always_comb begin
        rd_en1_o     = 1'b0;
        rd_en2_o     = 1'b0;
        rd_sel1_o    = '0;
        rd_sel2_o    = '0;
        wr_en_o      = 1'b0;
        wr_sel_o     = '0;
        sel_o        = SEL_DECODER;
        param_o      = '0;
        stat_wr_en_o = 1'b0;
        cnt_wr_en_o  = 1'b0;
        add_offset_o = 1'b0;
        flush_o      = 1'b0;
        illegal_o    = 1'b0;
        is_cond_o    = 1'b0;
        case (opcode_e'(opc))
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                rd_en1_o     = 1'b1;
                rd_en2_o     = 1'b1;
                rd_sel1_o    = op1;
                rd_sel2_o    = op2;
                wr_en_o      = 1'b1;
                wr_sel_o     = op1;
                sel_o        = SEL_ALU;
                stat_wr_en_o = 1'b1;
            end
            OP_NOT: begin
                rd_en2_o     = 1'b1;
                rd_sel2_o    = op2;
                wr_en_o      = 1'b1;
                wr_sel_o     = op1;
                sel_o        = SEL_ALU;
                stat_wr_en_o = 1'b1;
            end
            OP_SHL, OP_SHR: begin
                rd_en1_o     = 1'b1;
                rd_sel1_o    = op1;
                wr_en_o      = 1'b1;
                wr_sel_o     = op1;
                sel_o        = SEL_ALU;
                param_o      = prm;
                stat_wr_en_o = 1'b1;
            end
            OP_VAL: begin
                wr_en_o  = 1'b1;
                wr_sel_o = op1;
                sel_o    = SEL_DECODER;
                param_o  = prm;
            end
            OP_GOTO: begin
                cnt_wr_en_o = 1'b1;
                flush_o     = 1'b1;
                param_o     = prm;
            end
            OP_IFZ, OP_IFNZ, OP_IFEQ, OP_IFST, OP_IFGT: begin
                is_cond_o    = 1'b1;
                param_o      = prm;
                cnt_wr_en_o  = cond;
                add_offset_o = cond;
                flush_o      = cond;
            end
            OP_NOP: ;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Registered, handshaked decode stage. Holds conditional branches until the
// in-flight ALU status lands and drops the wrong-path instruction after a
// taken branch.
module decode_stage
    import jac_pkg::*;
#(
    parameter int INSTR_WIDTH = 16,
    parameter int OPCODE_BITS = 5,
    parameter int SEL_WIDTH   = 2,
    parameter int PARAM_BITS  = 8,
    parameter int STATUS_BITS = 6,
    parameter int OP1_POS     = 9,
    parameter int OP2_POS     = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INSTR_WIDTH-1:0] instruction,
    input  logic [STATUS_BITS-1:0] status,
    input  logic                   status_valid,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [OPCODE_BITS-1:0] opcode,
    output logic                   rd_en1,
    output logic                   rd_en2,
    output logic [SEL_WIDTH-1:0]   rd_sel1,
    output logic [SEL_WIDTH-1:0]   rd_sel2,
    output logic                   wr_en,
    output logic [SEL_WIDTH-1:0]   wr_sel,
    output logic                   sel_reg_in_alu_decoder,
    output logic [PARAM_BITS-1:0]  param,
    output logic                   stat_wr_en,
    output logic                   cnt_wr_en,
    output logic                   add_offset,
    output logic                   flush,
    output logic                   illegal
);

    state_e                 state_q;
    logic                   pend_q;
    logic [INSTR_WIDTH-1:0] cap_q;
    logic                   out_valid_q;
    logic [OPCODE_BITS-1:0] opcode_q;
    logic                   rd_en1_q, rd_en2_q, wr_en_q, sel_q;
    logic [SEL_WIDTH-1:0]   rd_sel1_q, rd_sel2_q, wr_sel_q;
    logic [PARAM_BITS-1:0]  param_q;
    logic                   stat_wr_en_q, cnt_wr_en_q, add_offset_q, flush_q, illegal_q;

    logic [INSTR_WIDTH-1:0] dec_instr;
    logic [OPCODE_BITS-1:0] opcode_d;
    logic                   rd_en1_d, rd_en2_d, wr_en_d, sel_d;
    logic [SEL_WIDTH-1:0]   rd_sel1_d, rd_sel2_d, wr_sel_d;
    logic [PARAM_BITS-1:0]  param_d;
    logic                   stat_wr_en_d, cnt_wr_en_d, add_offset_d, flush_d, illegal_d, is_cond_d;
    logic                   xfer, wait_go, run_load, wait_load, load;

    assign in_ready  = rst_n & (state_q != WAIT_FLAGS) & (!out_valid_q | out_ready);
    assign xfer      = in_valid & in_ready;
    // While waiting, decode the captured branch against the arriving status
    assign dec_instr = (state_q == WAIT_FLAGS) ? cap_q : instruction;
    assign wait_go   = (state_q == RUN) & xfer & is_cond_d & pend_q;
    assign run_load  = (state_q == RUN) & xfer & !wait_go;
    assign wait_load = (state_q == WAIT_FLAGS) & status_valid;
    assign load      = run_load | wait_load;

    decode_table #(
        .INSTR_WIDTH(INSTR_WIDTH), .OPCODE_BITS(OPCODE_BITS), .SEL_WIDTH(SEL_WIDTH),
        .PARAM_BITS(PARAM_BITS), .STATUS_BITS(STATUS_BITS),
        .OP1_POS(OP1_POS), .OP2_POS(OP2_POS)
    ) u_table (
        .instr_i(dec_instr), .status_i(status), .opcode_o(opcode_d),
        .rd_en1_o(rd_en1_d), .rd_en2_o(rd_en2_d), .rd_sel1_o(rd_sel1_d), .rd_sel2_o(rd_sel2_d),
        .wr_en_o(wr_en_d), .wr_sel_o(wr_sel_d), .sel_o(sel_d), .param_o(param_d),
        .stat_wr_en_o(stat_wr_en_d), .cnt_wr_en_o(cnt_wr_en_d), .add_offset_o(add_offset_d),
        .flush_o(flush_d), .illegal_o(illegal_d), .is_cond_o(is_cond_d)
    );

    // FSM, pending-flags tracker and registered output bundle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= RUN;
            pend_q       <= 1'b0;
            cap_q        <= '0;
            out_valid_q  <= 1'b0;
            opcode_q     <= '0;
            rd_en1_q     <= 1'b0;
            rd_en2_q     <= 1'b0;
            rd_sel1_q    <= '0;
            rd_sel2_q    <= '0;
            wr_en_q      <= 1'b0;
            wr_sel_q     <= '0;
            sel_q        <= 1'b0;
            param_q      <= '0;
            stat_wr_en_q <= 1'b0;
            cnt_wr_en_q  <= 1'b0;
            add_offset_q <= 1'b0;
            flush_q      <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            // Discarded instructions never write status, so they do not set it
            if (xfer && (state_q != KILL) && stat_wr_en_d) pend_q <= 1'b1;
            else if (status_valid)                         pend_q <= 1'b0;

            if (load) begin
                out_valid_q  <= 1'b1;
                opcode_q     <= opcode_d;
                rd_en1_q     <= rd_en1_d;
                rd_en2_q     <= rd_en2_d;
                rd_sel1_q    <= rd_sel1_d;
                rd_sel2_q    <= rd_sel2_d;
                wr_en_q      <= wr_en_d;
                wr_sel_q     <= wr_sel_d;
                sel_q        <= sel_d;
                param_q      <= param_d;
                stat_wr_en_q <= stat_wr_en_d;
                cnt_wr_en_q  <= cnt_wr_en_d;
                add_offset_q <= add_offset_d;
                flush_q      <= flush_d;
                illegal_q    <= illegal_d;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end

            case (state_q)
                RUN: begin
                    if (wait_go) begin
                        state_q <= WAIT_FLAGS;
                        cap_q   <= instruction;
                    end else if (run_load && flush_d) begin
                        state_q <= KILL;
                    end
                end
                WAIT_FLAGS: if (status_valid) state_q <= flush_d ? KILL : RUN;
                KILL:       if (xfer) state_q <= RUN;
                default:    state_q <= RUN;
            endcase
        end
    end

    assign out_valid              = out_valid_q;
    assign opcode                 = opcode_q;
    assign rd_en1                 = rd_en1_q;
    assign rd_en2                 = rd_en2_q;
    assign rd_sel1                = rd_sel1_q;
    assign rd_sel2                = rd_sel2_q;
    assign wr_en                  = wr_en_q;
    assign wr_sel                 = wr_sel_q;
    assign sel_reg_in_alu_decoder = sel_q;
    assign param                  = param_q;
    assign stat_wr_en             = stat_wr_en_q;
    assign cnt_wr_en              = cnt_wr_en_q;
    assign add_offset             = add_offset_q;
    assign flush                  = flush_q;
    assign illegal                = illegal_q;

endmodule
